// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: latches rising edges of device ready levels,
// masks and prioritises them, and hands one request at a time to the processor.
module intr_controller #(
  parameter int unsigned      DBITS      = 32,
  parameter logic [DBITS-1:0] IMASK_ADDR = DBITS'(32'hF000_0800),
  parameter logic [DBITS-1:0] IPEND_ADDR = DBITS'(32'hF000_0804),
  parameter logic [DBITS-1:0] IVEC_ADDR  = DBITS'(32'hF000_0808),
  parameter logic [DBITS-1:0] ICTRL_ADDR = DBITS'(32'hF000_080C)
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [DBITS-1:0] address,
  input  logic             wrtEn,
  input  logic [3:0]       srcReady,
  input  logic             intAck,
  output logic             intReq,
  output logic [1:0]       intId
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] prev_ready, pending, ovr, imask;
  logic            gie;

  logic [NSRC-1:0] rise, act, ack_clr, pend_clr, ovr_clr;
  logic [NSRC-1:0] pending_nxt, ovr_nxt;
  logic [IDW-1:0]  winner, int_id_nxt;
  logic            int_req_nxt;
  logic            wr_imask, wr_ipend, wr_ictrl, eoi;
  logic            rd_hit;
  logic [DBITS-1:0] rdata;
  logic            unused_dbus;

  assign unused_dbus = ^dbus[DBITS-1:8];

  // Bus decode
  assign wr_imask = wrtEn && (address == IMASK_ADDR);
  assign wr_ipend = wrtEn && (address == IPEND_ADDR);
  assign wr_ictrl = wrtEn && (address == ICTRL_ADDR);
  assign eoi      = wr_ictrl && dbus[2];

  assign rise = srcReady & ~prev_ready;
  assign act  = gie ? (pending & imask) : '0;

  // Lowest set index of act wins
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) winner = IDW'(i);
    end
  end

  // A new edge on a bit beats any clear of that bit in the same cycle
  always_comb begin
    ack_clr     = (state == REQ && intAck) ? (NSRC'(1) << intId) : '0;
    pend_clr    = (wr_ipend ? dbus[3:0] : '0) | ack_clr;
    ovr_clr     = wr_ipend ? dbus[7:4] : '0;
    pending_nxt = (pending & ~pend_clr) | rise;
    ovr_nxt     = (ovr & ~ovr_clr) | (rise & pending);
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      intReq     <= 1'b0;
      intId      <= '0;
      prev_ready <= srcReady;
      pending    <= '0;
      ovr        <= '0;
      imask      <= '0;
      gie        <= 1'b0;
    end else begin
      state      <= state_nxt;
      intReq     <= int_req_nxt;
      intId      <= int_id_nxt;
      prev_ready <= srcReady;
      pending    <= pending_nxt;
      ovr        <= ovr_nxt;
      if (wr_imask) imask <= dbus[3:0];
      if (wr_ictrl) gie   <= dbus[0];
    end
  end

  // Next-state logic; an acknowledge takes precedence over a withdraw
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (act != '0) state_nxt = REQ;
      REQ: begin
        if (intAck)            state_nxt = SERVICE;
        else if (!act[intId])  state_nxt = IDLE;
      end
      SERVICE: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic feeding the registered intReq/intId
  always_comb begin
    int_req_nxt = (state_nxt == REQ);
    int_id_nxt  = intId;
    if (state == IDLE && state_nxt == REQ) int_id_nxt = winner;
  end

  // Combinational register read-back
  always_comb begin
    rdata  = '0;
    rd_hit = 1'b1;
    if (address == IMASK_ADDR) begin
      rdata[3:0] = imask;
    end else if (address == IPEND_ADDR) begin
      rdata[7:0] = {ovr, pending};
    end else if (address == IVEC_ADDR) begin
      rdata[3:0] = {intReq, (state == SERVICE), intId};
    end else if (address == ICTRL_ADDR) begin
      rdata[0] = gie;
    end else begin
      rd_hit = 1'b0;
    end
  end

  assign dbus = (!wrtEn && rd_hit) ? rdata : 'z;

endmodule
